ex_mem_pipe_stage: RTL and testbench
====================================

// Module: ex_mem_pipe_stage
// PURPOSE
//  Parametrised EX->MEM pipeline stage: next generation of the EX/MEM latch. Replaces the global
//  stall vector with a per-stage valid/ready handshake, adds an optional 2-entry skid buffer for
//  full throughput under back-pressure, a synchronous flush, a NOP-bubble payload and a saturating
//  back-pressure counter. Sits between the EX stage (upstream) and the MEM stage (downstream).
// PARAMETERS
//  DATA_W     78      payload width {w_enable,w_addr[4:0],w_data[31:0],aluop[7:0],ram_addr[31:0]}
//  NOP_VALUE  78'h0   payload driven on dn_data whenever the stage holds no valid entry (bubble)
//  SKID       1       1: 2-entry skid buffer, up_ready registered; 0: single register, comb. up_ready
//  CNT_W      16      width of the back-pressure cycle counter
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  flush      in   1       discard all held entries (branch mispredict / exception)
//  up_valid   in   1       EX presents a valid payload
//  up_ready   out  1       stage accepts the payload this cycle
//  up_data    in   DATA_W  EX payload
//  dn_valid   out  1       stage presents a valid payload to MEM
//  dn_ready   in   1       MEM consumes dn_data this cycle
//  dn_data    out  DATA_W  payload to MEM; NOP_VALUE when dn_valid=0
//  occupancy  out  2       number of held entries (0..2; max 1 when SKID=0)
//  bp_cycles  out  CNT_W   saturating count of cycles with dn_valid=1 && dn_ready=0
// BEHAVIOUR
//  - One clock, synchronous active-high reset; all state updates on posedge clk.
//  - accept = up_valid && up_ready; drain = dn_valid && dn_ready.
//  - Reset: dn_valid=0, dn_data=NOP_VALUE, occupancy=0, bp_cycles=0, skid entry invalid,
//    up_ready=1 from the first cycle after reset. rst overrides flush and all handshakes.
//  - Priority: rst > flush > handshake. flush: next cycle occupancy=0, dn_valid=0,
//    dn_data=NOP_VALUE; an accept in the flush cycle is dropped; bp_cycles is NOT cleared.
//  - SKID=1 states (main=dn register, skid=overflow register):
//    EMPTY: accept -> ONE, main<=up_data. Else stay.
//    ONE:   accept&&drain -> ONE, main<=up_data; accept&&!drain -> TWO, skid<=up_data;
//           !accept&&drain -> EMPTY, main<=NOP_VALUE; else hold.
//    TWO:   up_ready=0; drain -> ONE, main<=skid, skid cleared; else hold.
//    up_ready is a register = (next state != TWO); no combinational path dn_ready->up_ready.
//  - SKID=0: states EMPTY/ONE only; up_ready = !dn_valid || dn_ready (combinational);
//    accept&&drain reloads main with up_data in the same cycle (zero-bubble).
//  - Latency: accepted payload appears on dn_data the cycle after accept (1 cycle) when the
//    stage was empty or draining; strict FIFO order always preserved, no payload lost/duplicated.
//  - dn_data is taken directly from the main register (no output mux); equals NOP_VALUE in EMPTY.
//  - dn_valid held with stable dn_data until drain (AXI-style; data never changes while stalled).
//  - bp_cycles increments by 1 on each cycle dn_valid&&!dn_ready, saturates at 2^CNT_W-1, no wrap.
//  - up_data with up_valid=0 is ignored; X on up_data when up_valid=0 must not propagate.
// TESTING
//  1 rst=1 3 cycles -> dn_valid=0, dn_data=NOP_VALUE, occupancy=0, bp_cycles=0, up_ready=1.
//  2 Stream A1..A8, dn_ready=1 always -> dn_data=A1..A8 one per cycle, 1-cycle latency, no gaps.
//  3 SKID=1: push A,B,C with dn_ready=0 -> occupancy=2, up_ready=0 after B, C held upstream;
//    raise dn_ready -> A,B,C out in order, bp_cycles = number of stalled cycles (e.g. 3).
//  4 flush while occupancy=2 and up_valid=1 (D) -> next cycle occupancy=0, dn_data=NOP_VALUE,
//    D not delivered; next accepted E emerges normally.
//  5 CNT_W=4, hold dn_valid=1 dn_ready=0 for 20 cycles -> bp_cycles saturates at 15.
//  6 SKID=0, random up_valid/dn_ready 10k cycles vs scoreboard -> order kept, occupancy<=1,
//    rst asserted mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage with a valid/ready handshake on both sides, an
// optional 2-entry skid buffer, synchronous flush, a NOP payload on bubbles
// and a saturating back-pressure cycle counter.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_EMPTY | no entry held; dn_data = NOP_VALUE, dn_valid = 0
// ST_ONE   | one entry held in r_main, presented downstream
// ST_TWO   | r_main presented, r_skid holds the next entry (SKID=1 only)
module ex_mem_pipe_stage #(
  parameter int unsigned       DATA_W    = 78,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter bit                SKID      = 1'b1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bp_cycles
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_up_ready;
  logic [CNT_W-1:0]  r_bp;

  logic w_accept;
  logic w_drain;
  logic w_stall;

  // The state encoding doubles as the occupancy count.
  assign dn_valid  = (r_state != ST_EMPTY);
  assign dn_data   = r_main;
  assign occupancy = r_state;
  assign bp_cycles = r_bp;

  // With the skid buffer, ready is a register so dn_ready never reaches
  // up_ready combinationally; without it, ready follows the downstream.
  assign up_ready = SKID ? r_up_ready : (!dn_valid || dn_ready);

  assign w_accept = up_valid && up_ready;
  assign w_drain  = dn_valid && dn_ready;
  assign w_stall  = dn_valid && !dn_ready;

  // Occupancy FSM: payload registers only load on an accepted handshake.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state    <= ST_EMPTY;
      r_main     <= NOP_VALUE;
      r_skid     <= NOP_VALUE;
      r_up_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state <= ST_ONE;
            r_main  <= up_data;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            r_main <= up_data;
          end else if (w_accept) begin
            // Only reachable with SKID=1; without the skid ready is low here.
            r_state    <= ST_TWO;
            r_skid     <= up_data;
            r_up_ready <= 1'b0;
          end else if (w_drain) begin
            r_state <= ST_EMPTY;
            r_main  <= NOP_VALUE;
          end
        end
        ST_TWO: begin
          if (w_drain) begin
            r_state    <= ST_ONE;
            r_main     <= r_skid;
            r_skid     <= NOP_VALUE;
            r_up_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_main     <= NOP_VALUE;
          r_skid     <= NOP_VALUE;
          r_up_ready <= 1'b1;
        end
      endcase
    end
  end

  // Saturating stall counter; flush deliberately leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bp <= '0;
    end else if (w_stall && (r_bp != {CNT_W{1'b1}})) begin
      r_bp <= r_bp + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: a skid instance (SKID=1, CNT_W=4, non-zero
// NOP) driven by directed vectors and a SKID=0 instance driven randomly.
// Expected payloads are queued on modelled accepts; monitors compare every cycle.
module tb_ex_mem_pipe_stage;

  localparam int          DW   = 78;
  localparam logic [77:0] NOP1 = 78'h0_0000_0000_DEAD_BEEF;
  localparam logic [77:0] NOP0 = 78'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // skid instance signals
  logic          rst1, flush1, up_valid1, up_ready1, dn_valid1, dn_ready1;
  logic [DW-1:0] up_data1, dn_data1;
  logic [1:0]    occ1;
  logic [3:0]    bp1;

  // no-skid instance signals
  logic          rst0, flush0, up_valid0, up_ready0, dn_valid0, dn_ready0;
  logic [DW-1:0] up_data0, dn_data0;
  logic [1:0]    occ0;
  logic [15:0]   bp0;

  ex_mem_pipe_stage #(.DATA_W(DW), .NOP_VALUE(NOP1), .SKID(1'b1), .CNT_W(4)) u_s1 (
    .clk(clk), .rst(rst1), .flush(flush1),
    .up_valid(up_valid1), .up_ready(up_ready1), .up_data(up_data1),
    .dn_valid(dn_valid1), .dn_ready(dn_ready1), .dn_data(dn_data1),
    .occupancy(occ1), .bp_cycles(bp1)
  );

  ex_mem_pipe_stage #(.DATA_W(DW), .NOP_VALUE(NOP0), .SKID(1'b0), .CNT_W(16)) u_s0 (
    .clk(clk), .rst(rst0), .flush(flush0),
    .up_valid(up_valid0), .up_ready(up_ready0), .up_data(up_data0),
    .dn_valid(dn_valid0), .dn_ready(dn_ready0), .dn_data(dn_data0),
    .occupancy(occ0), .bp_cycles(bp0)
  );

  task automatic chk(input string name, input logic [77:0] got, input logic [77:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // scoreboards
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];
  logic [3:0]    bpm1;
  logic [15:0]   bpm0;
  bit            armed1 = 1'b0;
  bit            armed0 = 1'b0;

  // skid monitor: compare outputs against the queue, then advance the model
  always @(negedge clk) begin
    if (armed1) begin
      chk("s1_up_ready",  78'(up_ready1), 78'(q1.size() != 2));
      chk("s1_dn_valid",  78'(dn_valid1), 78'(q1.size() != 0));
      chk("s1_occupancy", 78'(occ1),      78'(q1.size()));
      chk("s1_bp_cycles", 78'(bp1),       78'(bpm1));
      chk("s1_dn_data",   dn_data1,       (q1.size() != 0) ? q1[0] : NOP1);
    end
    if (rst1) begin
      q1.delete();
      bpm1   = '0;
      armed1 = 1'b1;
    end else if (armed1) begin
      if (q1.size() != 0 && !dn_ready1 && bpm1 != 4'hF) bpm1 = bpm1 + 4'd1;
      if (flush1) begin
        q1.delete();
      end else begin
        logic acc;
        acc = up_valid1 && (q1.size() != 2);
        if (q1.size() != 0 && dn_ready1) void'(q1.pop_front());
        if (acc) q1.push_back(up_data1);
      end
    end
  end

  // no-skid monitor
  always @(negedge clk) begin
    if (armed0) begin
      chk("s0_up_ready",  78'(up_ready0), 78'(q0.size() == 0 || dn_ready0));
      chk("s0_dn_valid",  78'(dn_valid0), 78'(q0.size() != 0));
      chk("s0_occupancy", 78'(occ0),      78'(q0.size()));
      chk("s0_bp_cycles", 78'(bp0),       78'(bpm0));
      chk("s0_dn_data",   dn_data0,       (q0.size() != 0) ? q0[0] : NOP0);
    end
    if (rst0) begin
      q0.delete();
      bpm0   = '0;
      armed0 = 1'b1;
    end else if (armed0) begin
      if (q0.size() != 0 && !dn_ready0 && bpm0 != 16'hFFFF) bpm0 = bpm0 + 16'd1;
      if (flush0) begin
        q0.delete();
      end else begin
        logic acc;
        acc = up_valid0 && (q0.size() == 0 || dn_ready0);
        if (q0.size() != 0 && dn_ready0) void'(q0.pop_front());
        if (acc) q0.push_back(up_data0);
      end
    end
  end

  // one cycle on the skid instance: inputs are taken at the next rising edge
  task automatic s1(input logic v, input logic [77:0] d, input logic r, input logic f);
    up_valid1 = v;
    up_data1  = d;
    dn_ready1 = r;
    flush1    = f;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [77:0] pay(input int tag);
    logic [77:0] p;
    p = {1'b1, 5'(tag), 32'hC0DE_0000 + 32'(tag), 8'(tag * 3), 32'h1000_0000 + 32'(tag * 4)};
    return p;
  endfunction

  initial begin
    rst1 = 1'b1; flush1 = 1'b0; up_valid1 = 1'b0; up_data1 = '0; dn_ready1 = 1'b0;
    rst0 = 1'b1; flush0 = 1'b0; up_valid0 = 1'b0; up_data0 = '0; dn_ready0 = 1'b0;

    // reset state
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst1 = 1'b0;
    rst0 = 1'b0;
    chk("rst_s1_dn_valid", 78'(dn_valid1), 78'(0));
    chk("rst_s1_dn_data",  dn_data1,       NOP1);
    chk("rst_s1_occ",      78'(occ1),      78'(0));
    chk("rst_s1_bp",       78'(bp1),       78'(0));
    chk("rst_s1_up_ready", 78'(up_ready1), 78'(1));
    chk("rst_s0_dn_data",  dn_data0,       NOP0);
    chk("rst_s0_up_ready", 78'(up_ready0), 78'(1));

    // back-to-back stream, no back-pressure
    for (int i = 1; i <= 8; i++) begin
      s1(1'b1, pay(i), 1'b1, 1'b0);
      chk("stream_dn_data", dn_data1, pay(i));
    end
    s1(1'b0, '0, 1'b1, 1'b0);
    s1(1'b0, '0, 1'b1, 1'b0);

    // fill the skid buffer under back-pressure
    s1(1'b1, pay(20), 1'b0, 1'b0);
    s1(1'b1, pay(21), 1'b0, 1'b0);
    chk("fill_occ_after_b",   78'(occ1),      78'(2));
    chk("fill_ready_after_b", 78'(up_ready1), 78'(0));
    s1(1'b1, pay(22), 1'b0, 1'b0);
    s1(1'b1, pay(22), 1'b0, 1'b0);
    chk("fill_head_held", dn_data1, pay(20));
    s1(1'b1, pay(22), 1'b1, 1'b0);
    chk("drain_a_next_b", dn_data1, pay(21));
    s1(1'b1, pay(22), 1'b1, 1'b0);
    chk("drain_b_next_c", dn_data1, pay(22));
    s1(1'b0, '0, 1'b1, 1'b0);
    s1(1'b0, '0, 1'b1, 1'b0);
    chk("fill_bp_cycles", 78'(bp1),  78'(3));
    chk("fill_empty_occ", 78'(occ1), 78'(0));

    // flush with two entries held and a new payload offered
    s1(1'b1, pay(30), 1'b0, 1'b0);
    s1(1'b1, pay(31), 1'b0, 1'b0);
    chk("flush_pre_occ", 78'(occ1), 78'(2));
    s1(1'b1, pay(29), 1'b0, 1'b1);
    chk("flush_occ",      78'(occ1),      78'(0));
    chk("flush_dn_valid", 78'(dn_valid1), 78'(0));
    chk("flush_dn_data",  dn_data1,       NOP1);
    chk("flush_bp_kept",  78'(bp1),       78'(5));
    s1(1'b1, pay(28), 1'b1, 1'b0);
    chk("post_flush_e", dn_data1, pay(28));
    s1(1'b0, '0, 1'b1, 1'b0);
    s1(1'b0, '0, 1'b1, 1'b0);

    // saturate the 4-bit stall counter
    s1(1'b1, pay(7), 1'b0, 1'b0);
    repeat (20) s1(1'b0, '0, 1'b0, 1'b0);
    chk("sat_bp_15", 78'(bp1), 78'(15));
    s1(1'b0, '0, 1'b1, 1'b0);
    s1(1'b0, '0, 1'b1, 1'b0);
    chk("sat_bp_hold", 78'(bp1), 78'(15));

    // random traffic on the zero-bubble instance with a mid-stream reset
    for (int i = 0; i < 10000; i++) begin
      up_valid0 = ($urandom_range(0, 3) != 0);
      up_data0  = up_valid0 ? {$urandom(), $urandom(), $urandom()} : 'x;
      dn_ready0 = ($urandom_range(0, 2) != 0);
      flush0    = ($urandom_range(0, 199) == 0);
      rst0      = (i == 5000);
      @(posedge clk);
      #1;
      if (i == 5000) begin
        chk("midrst_dn_valid", 78'(dn_valid0), 78'(0));
        chk("midrst_dn_data",  dn_data0,       NOP0);
        chk("midrst_occ",      78'(occ0),      78'(0));
        chk("midrst_bp",       78'(bp0),       78'(0));
      end
    end
    rst0 = 1'b0; up_valid0 = 1'b0; dn_ready0 = 1'b1; flush0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
